// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller that sequences 8-bit instructions through an external ALU
module alu_sequencer #(
  parameter int REG_AW = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] instr_in,
  input  logic       instr_valid_in,
  output logic       instr_ready_out,
  output logic [2:0] unit_sel_out,
  output logic       op_sel_out,
  output logic [7:0] acc_out,
  output logic [7:0] src_out,
  input  logic [7:0] alu_res_in,
  output logic       done_out,
  output logic       branch_taken_out,
  output logic [7:0] branch_off_out,
  output logic       illegal_out
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [7:0] instr;
  logic [7:0] acc;
  logic [7:0] regs [2**REG_AW];
  logic [2:0] cnt;
  logic [3:0] op;
  logic [3:0] imm;
  logic [REG_AW-1:0] idx;
  logic exec;
  assign op = instr[7:4];
  assign imm = instr[3:0];
  assign idx = instr[REG_AW-1:0];
  assign exec = state == EXEC;
  assign instr_ready_out = state == IDLE;
  assign acc_out = acc;
  always_comb begin
    unit_sel_out = !exec ? 3'b111 :
                   op < 4'h2 || op == 4'hD ? 3'b000 :
                   op < 4'h4 ? 3'b001 :
                   op < 4'h6 ? 3'b010 :
                   op == 4'h6 || op == 4'hA ? 3'b011 :
                   op == 4'h7 ? 3'b100 :
                   op == 4'h8 ? 3'b101 :
                   op == 4'h9 ? 3'b110 : 3'b111;
    op_sel_out = exec && op < 4'h6 && op[0];
    src_out = !exec ? 8'h00 : (op == 4'hA || op == 4'hD) ? {4'b0, imm} : regs[idx];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      instr <= '0;
      acc <= '0;
      cnt <= '0;
      done_out <= 1'b0;
      branch_taken_out <= 1'b0;
      branch_off_out <= '0;
      illegal_out <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid_in) begin
          instr <= instr_in;
          cnt <= instr_in[7:4] == 4'h9 ? 3'(MUL_CYCLES - 1) : 3'd0;
          state <= EXEC;
        end
        EXEC: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        else begin
          state <= DONE;
          done_out <= 1'b1;
          if (op <= 4'hA || op == 4'hD) acc <= alu_res_in;
          if (op == 4'hB) regs[idx] <= alu_res_in;
          if (op == 4'hC) begin
            branch_taken_out <= |alu_res_in;
            branch_off_out <= {{4{imm[3]}}, imm};
          end
          illegal_out <= op[3:1] == 3'b111;
        end
        DONE: begin
          done_out <= 1'b0;
          branch_taken_out <= 1'b0;
          illegal_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an opcode-level reference model and a behavioural ALU
module tb_alu_sequencer;
  localparam int MC = 2;
  logic clk = 0, rst = 1;
  logic [7:0] instr = 0;
  logic valid = 0, ready;
  logic [2:0] unit_sel;
  logic op_sel;
  logic [7:0] acc, src, alu_res, branch_off;
  logic done, branch_taken, illegal;
  alu_sequencer #(.REG_AW(2), .MUL_CYCLES(MC)) dut (
    .clk_in(clk), .rst_in(rst), .instr_in(instr), .instr_valid_in(valid),
    .instr_ready_out(ready), .unit_sel_out(unit_sel), .op_sel_out(op_sel),
    .acc_out(acc), .src_out(src), .alu_res_in(alu_res), .done_out(done),
    .branch_taken_out(branch_taken), .branch_off_out(branch_off), .illegal_out(illegal)
  );
  always #5 clk = ~clk;
  always_comb begin
    logic [15:0] p;
    p = acc * src;
    case (unit_sel)
      3'd0: alu_res = op_sel ? acc - src : acc + src;
      3'd1: alu_res = op_sel ? ~(acc & src) : acc & src;
      3'd2: alu_res = op_sel ? acc >> src[2:0] : acc << src[2:0];
      3'd3: alu_res = src;
      3'd4: alu_res = acc | src;
      3'd5: alu_res = acc ^ src;
      3'd6: alu_res = p[7:0];
      default: alu_res = acc;
    endcase
  end
  typedef struct {logic [7:0] acc; logic br; logic [7:0] off; logic ill; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, busy = 0;
  logic [7:0] m_acc = 0;
  logic [7:0] m_regs [4] = '{default: 0};
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s got %0h want %0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  function automatic exp_t model(input logic [7:0] ins);
    exp_t e;
    logic [3:0] o, im;
    logic [7:0] r;
    int m;
    o = ins[7:4];
    im = ins[3:0];
    r = m_regs[ins[1:0]];
    e.br = 0; e.off = 0; e.ill = 0;
    case (o)
      4'h0: m_acc = m_acc + r;
      4'h1: m_acc = m_acc - r;
      4'h2: m_acc = m_acc & r;
      4'h3: m_acc = ~(m_acc & r);
      4'h4: m_acc = m_acc << (r % 8);
      4'h5: m_acc = m_acc >> (r % 8);
      4'h6: m_acc = r;
      4'h7: m_acc = m_acc | r;
      4'h8: m_acc = m_acc ^ r;
      4'h9: begin m = int'(m_acc) * int'(r); m_acc = 8'(m % 256); end
      4'hA: m_acc = {4'b0, im};
      4'hB: m_regs[ins[1:0]] = m_acc;
      4'hC: begin e.br = m_acc != 0; e.off = 8'(int'($signed(im))); end
      4'hD: m_acc = m_acc + {4'b0, im};
      default: e.ill = 1;
    endcase
    e.acc = m_acc;
    e.due = cyc + (o == 4'h9 ? MC + 1 : 2);
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) busy = 0;
    else if (busy > 0) begin
      chk("ready_busy", ready, 0);
      busy--;
    end else if (valid && ready) begin
      q.push_back(model(instr));
      busy = instr[7:4] == 4'h9 ? MC + 1 : 2;
    end
  end
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("acc", acc, e.acc);
        chk("branch_taken", branch_taken, e.br);
        chk("illegal", illegal, e.ill);
        if (e.br) chk("branch_off", branch_off, e.off);
      end
    end else if (!rst && (branch_taken || illegal)) chk("pulse_without_done", 1, 0);
  end
  task automatic issue(input logic [7:0] ins);
    @(posedge clk) #1;
    instr = ins;
    valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        @(posedge clk) #1;
        valid = 0;
        return;
      end
    end
    valid = 0;
    chk("accept_timeout", 1, 0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) return;
    end
    chk("done_timeout", 1, 0);
  endtask
  task automatic run(input logic [7:0] ins);
    issue(ins);
    wait_idle();
  endtask
  task automatic runs(input logic [7:0] s [$]);
    foreach (s[i]) run(s[i]);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_unit", unit_sel, 7);
    chk("rst_src", src, 0);
    chk("rst_off", branch_off, 0);
    rst = 0;
    runs('{8'hA5, 8'hB1, 8'h01});
    chk("t1_add", acc, 8'h0A);
    runs('{8'hA0, 8'h01});
    chk("t1_r1", acc, 8'h05);
    runs('{8'hA3, 8'h11});
    chk("t2_sub", acc, 8'hFE);
    runs('{8'hA2, 8'hB3, 8'hAF, 8'h43, 8'hB2, 8'hA4, 8'hB0, 8'hAF, 8'h40, 8'h32});
    chk("t2_nand", acc, 8'hCF);
    runs('{8'hA7, 8'hB3, 8'hA1, 8'hB0, 8'h43, 8'h70});
    chk("t3_acc81", acc, 8'h81);
    run(8'h50);
    chk("t3_shr", acc, 8'h40);
    runs('{8'hAB, 8'hB1, 8'hA1, 8'h41});
    chk("t3_shl", acc, 8'h08);
    runs('{8'hA1, 8'hB0, 8'hA4, 8'hB3, 8'hA1, 8'h43, 8'h70, 8'hB2, 8'hA1, 8'h43});
    chk("t4_acc10", acc, 8'h10);
    issue(8'h92);
    @(negedge clk);
    chk("t4_unit_c1", unit_sel, 6);
    chk("t4_src_c1", src, 8'h11);
    @(negedge clk);
    chk("t4_unit_c2", unit_sel, 6);
    chk("t4_done_c2", done, 0);
    @(negedge clk);
    chk("t4_done_c3", done, 1);
    chk("t4_unit_c3", unit_sel, 7);
    chk("t4_mul", acc, 8'h10);
    wait_idle();
    run(8'hA1);
    issue(8'hCE);
    repeat (2) @(negedge clk);
    chk("t5_taken", branch_taken, 1);
    chk("t5_off", branch_off, 8'hFE);
    wait_idle();
    run(8'hA0);
    issue(8'hCE);
    repeat (2) @(negedge clk);
    chk("t5_not_taken", branch_taken, 0);
    wait_idle();
    issue(8'hF0);
    repeat (2) @(negedge clk);
    chk("t5_illegal", illegal, 1);
    chk("t5_ill_acc", acc, 0);
    wait_idle();
    @(posedge clk) #1;
    valid = 1;
    instr = 8'($urandom);
    for (int n = 0; n < 300; ) begin
      @(negedge clk);
      if (ready) begin
        n++;
        @(posedge clk) #1;
        instr = 8'($urandom);
      end
    end
    valid = 0;
    wait_idle();
    runs('{8'hA7, 8'hB2, 8'hA6});
    issue(8'h92);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_unit", unit_sel, 7);
    chk("mid_rst_src", src, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    m_acc = 0;
    m_regs = '{default: 0};
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    run(8'h02);
    chk("post_rst_regs_clear", acc, 0);
    runs('{8'hA9, 8'hD7});
    chk("post_rst_addi", acc, 8'h10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
